// File: rtl/lab2_proc_mul_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : lab2_proc_mul_issue_ctrl_if
// Brief  : X-stage / multiplier handshake and status bundle for the issue ctrl.
// Rev    : 1.0
// ============================================================================
interface lab2_proc_mul_issue_ctrl_if #(
    parameter int p_cnt_nbits = 16
);
    logic                   mul_val_X;
    logic                   squash_X;
    logic                   ostall_down_X;
    logic                   mul_req_val;
    logic                   mul_req_rdy;
    logic                   mul_resp_val;
    logic                   mul_resp_rdy;
    logic                   ostall_mul_X;
    logic                   ex_result_sel_X;
    logic                   mul_busy;
    logic [p_cnt_nbits-1:0] mul_count;
    logic [p_cnt_nbits-1:0] mul_stall_count;

    modport master (
        input  mul_val_X, squash_X, ostall_down_X, mul_req_rdy, mul_resp_val,
        output mul_req_val, mul_resp_rdy, ostall_mul_X, ex_result_sel_X,
               mul_busy, mul_count, mul_stall_count
    );

    modport slave (
        output mul_val_X, squash_X, ostall_down_X, mul_req_rdy, mul_resp_val,
        input  mul_req_val, mul_resp_rdy, ostall_mul_X, ex_result_sel_X,
               mul_busy, mul_count, mul_stall_count
    );
endinterface
`default_nettype wire

// File: rtl/lab2_proc_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : lab2_proc_mul_issue_ctrl
// Brief  : Issue, stall, drain and result-steer control for the X-stage
//          iterative multiplier, with issue and stall performance counters.
// Rev    : 1.0
// ============================================================================
module lab2_proc_mul_issue_ctrl #(
    parameter int p_cnt_nbits = 16
) (
    input  wire logic                       clk,
    input  wire logic                       reset,
    lab2_proc_mul_issue_ctrl_if.master      bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CALC  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [p_cnt_nbits-1:0] mul_count_q;
    logic [p_cnt_nbits-1:0] mul_count_d;
    logic [p_cnt_nbits-1:0] stall_count_q;
    logic [p_cnt_nbits-1:0] stall_count_d;

    logic w_go;
    logic w_req_val;
    logic w_resp_rdy;
    logic w_stall;
    logic w_sel;
    logic w_busy;
    logic w_count_inc;

    assign w_go = bus.mul_val_X & ~bus.squash_X;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            mul_count_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            mul_count_q   <= mul_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_go && bus.mul_req_rdy)
                    state_d = ST_CALC;
            end
            ST_CALC: begin
                if (bus.mul_resp_val && w_resp_rdy)
                    state_d = ST_IDLE;
                else if (bus.squash_X && !bus.mul_resp_val)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.mul_resp_val)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so they drop asynchronously.
    always_comb begin
        w_req_val   = 1'b0;
        w_resp_rdy  = 1'b0;
        w_stall     = 1'b0;
        w_sel       = 1'b0;
        w_busy      = 1'b0;
        w_count_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_req_val = w_go;
                w_stall   = w_go;
            end
            ST_CALC: begin
                w_busy      = 1'b1;
                w_resp_rdy  = bus.squash_X | ~bus.ostall_down_X;
                w_sel       = bus.mul_resp_val & ~bus.squash_X;
                w_stall     = w_go & ~bus.mul_resp_val;
                w_count_inc = bus.mul_resp_val & w_resp_rdy & ~bus.squash_X;
            end
            ST_DRAIN: begin
                w_busy     = 1'b1;
                w_resp_rdy = 1'b1;
                w_stall    = w_go;
            end
            default: ;
        endcase
        if (reset) begin
            w_req_val   = 1'b0;
            w_resp_rdy  = 1'b0;
            w_stall     = 1'b0;
            w_sel       = 1'b0;
            w_busy      = 1'b0;
            w_count_inc = 1'b0;
        end
    end

    always_comb begin
        mul_count_d   = mul_count_q + p_cnt_nbits'(w_count_inc);
        stall_count_d = stall_count_q + p_cnt_nbits'(w_stall);
    end

    assign bus.mul_req_val     = w_req_val;
    assign bus.mul_resp_rdy    = w_resp_rdy;
    assign bus.ostall_mul_X    = w_stall;
    assign bus.ex_result_sel_X = w_sel;
    assign bus.mul_busy        = w_busy;
    assign bus.mul_count       = mul_count_q;
    assign bus.mul_stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_lab2_proc_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_lab2_proc_mul_issue_ctrl
// Brief  : Self-checking bench for the multiplier issue controller.
// Rev    : 1.0
// ============================================================================
module tb_lab2_proc_mul_issue_ctrl;

    logic clk;
    logic reset;

    lab2_proc_mul_issue_ctrl_if #(.p_cnt_nbits(16)) bus  ();
    lab2_proc_mul_issue_ctrl_if #(.p_cnt_nbits(2))  bus2 ();

    lab2_proc_mul_issue_ctrl #(.p_cnt_nbits(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    lab2_proc_mul_issue_ctrl #(.p_cnt_nbits(2)) dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks  = 0;
    int n_fail    = 0;
    int req_fires = 0;
    int exp_q[$];

    typedef struct {
        logic mv, sq, rr;
        logic e_req, e_stall, e_busy;
    } idle_vec_t;

    typedef struct {
        logic mv, sq, od, rv;
        logic e_rdy, e_sel, e_stall;
        logic [1:0] e_next;
        logic e_inc;
    } calc_vec_t;

    idle_vec_t idle_tbl[8];
    calc_vec_t calc_tbl[16];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input logic mv, input logic sq, input logic od,
                       input logic rr, input logic rv);
        bus.mul_val_X     = mv;
        bus.squash_X      = sq;
        bus.ostall_down_X = od;
        bus.mul_req_rdy   = rr;
        bus.mul_resp_val  = rv;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        #3;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    // Scoreboard: each consumed product must match the next queued count.
    always @(posedge clk) begin
        if (bus.mul_req_val && bus.mul_req_rdy) req_fires++;
        if (bus.ex_result_sel_X && bus.mul_resp_rdy && bus.mul_resp_val) begin
            #1;
            if (exp_q.size() == 0) chk("sb_pending", exp_q.size(), 1);
            else                   chk("sb_mul_count", int'(bus.mul_count), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rf0;
        idle_tbl[0] = '{1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
        idle_tbl[1] = '{1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
        idle_tbl[2] = '{1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0};
        idle_tbl[3] = '{1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0};
        idle_tbl[4] = '{1'b1,1'b0,1'b0, 1'b1,1'b1,1'b0};
        idle_tbl[5] = '{1'b1,1'b0,1'b1, 1'b1,1'b1,1'b1};
        idle_tbl[6] = '{1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0};
        idle_tbl[7] = '{1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0};

        //               mv   sq   od   rv    rdy  sel  stall next inc
        calc_tbl[0]  = '{1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 2'd1,1'b0};
        calc_tbl[1]  = '{1'b0,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 2'd0,1'b1};
        calc_tbl[2]  = '{1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b0, 2'd1,1'b0};
        calc_tbl[3]  = '{1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 2'd1,1'b0};
        calc_tbl[4]  = '{1'b0,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 2'd2,1'b0};
        calc_tbl[5]  = '{1'b0,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0, 2'd0,1'b0};
        calc_tbl[6]  = '{1'b0,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 2'd2,1'b0};
        calc_tbl[7]  = '{1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0, 2'd0,1'b0};
        calc_tbl[8]  = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b1, 2'd1,1'b0};
        calc_tbl[9]  = '{1'b1,1'b0,1'b0,1'b1, 1'b1,1'b1,1'b0, 2'd0,1'b1};
        calc_tbl[10] = '{1'b1,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1, 2'd1,1'b0};
        calc_tbl[11] = '{1'b1,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0, 2'd1,1'b0};
        calc_tbl[12] = '{1'b1,1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0, 2'd2,1'b0};
        calc_tbl[13] = '{1'b1,1'b1,1'b0,1'b1, 1'b1,1'b0,1'b0, 2'd0,1'b0};
        calc_tbl[14] = '{1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0, 2'd2,1'b0};
        calc_tbl[15] = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0, 2'd0,1'b0};

        bus2.mul_val_X = 1'b0; bus2.squash_X = 1'b0; bus2.ostall_down_X = 1'b0;
        bus2.mul_req_rdy = 1'b0; bus2.mul_resp_val = 1'b0;

        // Reset state, including outputs held low with a pending mul.
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_req_val", int'(bus.mul_req_val), 0);
        chk("rst_stall", int'(bus.ostall_mul_X), 0);
        chk("rst_busy", int'(bus.mul_busy), 0);
        chk("rst_count", int'(bus.mul_count), 0);
        chk("rst_stall_count", int'(bus.mul_stall_count), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #10;
        reset = 1'b0;
        tick();

        // IDLE-state truth table.
        for (int i = 0; i < 8; i++) begin
            rst_pulse();
            cyc(idle_tbl[i].mv, idle_tbl[i].sq, 1'b0, idle_tbl[i].rr, 1'b0);
            chk($sformatf("idle%0d_req_val", i), int'(bus.mul_req_val), int'(idle_tbl[i].e_req));
            chk($sformatf("idle%0d_stall", i), int'(bus.ostall_mul_X), int'(idle_tbl[i].e_stall));
            chk($sformatf("idle%0d_sel", i), int'(bus.ex_result_sel_X), 0);
            chk($sformatf("idle%0d_resp_rdy", i), int'(bus.mul_resp_rdy), 0);
            tick();
            chk($sformatf("idle%0d_busy", i), int'(bus.mul_busy), int'(idle_tbl[i].e_busy));
            chk($sformatf("idle%0d_stall_cnt", i), int'(bus.mul_stall_count), int'(idle_tbl[i].e_stall));
        end

        // CALC-state truth table; next state probed through busy/resp_rdy.
        for (int i = 0; i < 16; i++) begin
            rst_pulse();
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            cyc(calc_tbl[i].mv, calc_tbl[i].sq, calc_tbl[i].od, 1'b1, calc_tbl[i].rv);
            chk($sformatf("calc%0d_req_val", i), int'(bus.mul_req_val), 0);
            chk($sformatf("calc%0d_resp_rdy", i), int'(bus.mul_resp_rdy), int'(calc_tbl[i].e_rdy));
            chk($sformatf("calc%0d_sel", i), int'(bus.ex_result_sel_X), int'(calc_tbl[i].e_sel));
            chk($sformatf("calc%0d_stall", i), int'(bus.ostall_mul_X), int'(calc_tbl[i].e_stall));
            if (calc_tbl[i].e_inc) exp_q.push_back(1);
            tick();
            chk($sformatf("calc%0d_count", i), int'(bus.mul_count), int'(calc_tbl[i].e_inc));
            chk($sformatf("calc%0d_stall_cnt", i), int'(bus.mul_stall_count), 1 + int'(calc_tbl[i].e_stall));
            cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            chk($sformatf("calc%0d_next_busy", i), int'(bus.mul_busy), (calc_tbl[i].e_next != 2'd0) ? 1 : 0);
            chk($sformatf("calc%0d_next_drain", i), int'(bus.mul_resp_rdy), (calc_tbl[i].e_next == 2'd2) ? 1 : 0);
        end

        // Single mul, latency 4.
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("lat4_c0_req", int'(bus.mul_req_val), 1);
        chk("lat4_c0_stall", int'(bus.ostall_mul_X), 1);
        exp_q.push_back(1);
        tick();
        for (int c = 1; c < 4; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk($sformatf("lat4_c%0d_stall", c), int'(bus.ostall_mul_X), 1);
            chk($sformatf("lat4_c%0d_req", c), int'(bus.mul_req_val), 0);
            tick();
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("lat4_c4_sel", int'(bus.ex_result_sel_X), 1);
        chk("lat4_c4_stall", int'(bus.ostall_mul_X), 0);
        chk("lat4_c4_resp_rdy", int'(bus.mul_resp_rdy), 1);
        tick();
        chk("lat4_count", int'(bus.mul_count), 1);
        chk("lat4_stall_count", int'(bus.mul_stall_count), 4);
        chk("lat4_idle", int'(bus.mul_busy), 0);

        // Back-to-back muls, latency 2.
        rst_pulse();
        rf0 = req_fires;
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); exp_q.push_back(1); tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("b2b_no_issue_in_calc", int'(bus.mul_req_val), 0);
        tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("b2b_second_issue", int'(bus.mul_req_val), 1);
        exp_q.push_back(2);
        tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); tick();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b_count", int'(bus.mul_count), 2);
        chk("b2b_req_fires", req_fires - rf0, 2);

        // Downstream stall holds the response.
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); exp_q.push_back(1); tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        for (int c = 3; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            chk($sformatf("dstall_c%0d_resp_rdy", c), int'(bus.mul_resp_rdy), 0);
            chk($sformatf("dstall_c%0d_sel", c), int'(bus.ex_result_sel_X), 1);
            tick();
            chk($sformatf("dstall_c%0d_busy", c), int'(bus.mul_busy), 1);
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("dstall_c5_resp_rdy", int'(bus.mul_resp_rdy), 1);
        tick();
        chk("dstall_count", int'(bus.mul_count), 1);
        chk("dstall_stall_count", int'(bus.mul_stall_count), 3);

        // Squash mid-calc, orphan drained, then a new mul issues.
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("sq_c1_stall", int'(bus.ostall_mul_X), 0);
        tick();
        for (int c = 2; c < 5; c++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("sq_c%0d_stall", c), int'(bus.ostall_mul_X), 1);
            chk($sformatf("sq_c%0d_req", c), int'(bus.mul_req_val), 0);
            chk($sformatf("sq_c%0d_resp_rdy", c), int'(bus.mul_resp_rdy), 1);
            tick();
        end
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("sq_c5_sel", int'(bus.ex_result_sel_X), 0);
        chk("sq_c5_req", int'(bus.mul_req_val), 0);
        tick();
        chk("sq_c5_count", int'(bus.mul_count), 0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sq_c6_req", int'(bus.mul_req_val), 1);
        exp_q.push_back(1);
        tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1); tick();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("sq_count", int'(bus.mul_count), 1);
        chk("sq_stall_count", int'(bus.mul_stall_count), 6);

        // Squash coincident with the response.
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("sqr_resp_rdy", int'(bus.mul_resp_rdy), 1);
        chk("sqr_sel", int'(bus.ex_result_sel_X), 0);
        tick();
        chk("sqr_idle", int'(bus.mul_busy), 0);
        chk("sqr_count", int'(bus.mul_count), 0);

        // Asynchronous reset in the middle of a CALC cycle.
        rst_pulse();
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("areset_pre_stall", int'(bus.ostall_mul_X), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_stall", int'(bus.ostall_mul_X), 0);
        chk("areset_busy", int'(bus.mul_busy), 0);
        chk("areset_stall_count", int'(bus.mul_stall_count), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk("areset_idle_after", int'(bus.mul_busy), 0);

        // Narrow counters wrap.
        for (int m = 0; m < 5; m++) begin
            bus2.mul_val_X = 1'b1; bus2.mul_req_rdy = 1'b1; bus2.mul_resp_val = 1'b0;
            tick();
            bus2.mul_resp_val = 1'b1;
            tick();
            bus2.mul_val_X = 1'b0; bus2.mul_resp_val = 1'b0;
            if (m == 3) chk("wrap_count_4", int'(bus2.mul_count), 0);
        end
        #1;
        chk("wrap_count_5", int'(bus2.mul_count), 1);
        chk("wrap_stall_count_5", int'(bus2.mul_stall_count), 1);

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
